// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, constants and fetch-state encoding for the CPU.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int              INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_pc_next_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_next_sel
// Brief    : Next-PC selector: word-aligned redirect target, pc+4, or hold.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            taken,
  input  logic            advance,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_next
);
  import cpu_pkg::*;

  logic [XLEN-1:0] w_target_aligned;

  // Low two target bits are forced to zero; a redirect always wins over advancing.
  assign w_target_aligned = target & ~XLEN'(3);

  always_comb begin
    pc_next = pc;
    if (taken) begin
      pc_next = w_target_aligned;
    end else if (advance) begin
      pc_next = pc + XLEN'(INSTR_BYTES);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Owns the PC, fetches over req/ack, hands instructions to decode.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int              XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            branch,
  input  logic            zero_flag,
  input  logic [XLEN-1:0] pc_branch
);
  import cpu_pkg::*;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_instr;
  logic            r_out_valid;

  logic            w_taken;
  logic            w_advance;
  logic [XLEN-1:0] w_pc_next;

  assign w_taken   = branch & zero_flag;
  // out_valid is always high in S_HOLD, so the handshake reduces to out_ready.
  assign w_advance = (r_state == S_HOLD) & out_ready;

  pc_next_sel #(
    .XLEN (XLEN)
  ) u_pc_next_sel (
    .pc      (r_pc),
    .taken   (w_taken),
    .advance (w_advance),
    .target  (pc_branch),
    .pc_next (w_pc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= NOP_INSTR;
    end else begin
      r_pc <= w_pc_next;
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
          r_addr  <= w_pc_next;
        end
        S_FETCH: begin
          if (w_taken) begin
            // Without an ack the old request must be completed and dropped first.
            r_state <= imem_ack ? S_FETCH : S_DISCARD;
            if (imem_ack) begin
              r_addr <= w_pc_next;
            end
          end else if (imem_ack) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc;
            r_out_instr <= imem_rdata;
          end
        end
        S_HOLD: begin
          if (w_taken || out_ready) begin
            r_state     <= S_FETCH;
            r_out_valid <= 1'b0;
            r_addr      <= w_pc_next;
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            r_state <= S_FETCH;
            r_addr  <= w_pc_next;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign imem_req  = (r_state == S_FETCH) || (r_state == S_DISCARD);
  assign imem_addr = r_addr;
  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_instr = r_out_valid ? r_out_instr : NOP_INSTR;

endmodule
`default_nettype wire
